// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Brief    : Shares one 1-cycle-latency single-port RAM between the fetch
//            and data ports, with a data address window and byte steering.
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
  parameter int          ADDR_W       = 16,
  parameter logic [31:0] BASE         = 32'h80000000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_oe,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic [31:0]       d_addr,
  input  logic              d_oe,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_overrun,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic               r_i_pend;
  logic [ADDR_W-1:0]  r_i_pend_addr;
  logic               r_i_infl;
  logic [31:0]        r_i_hold;

  logic               r_d_pend;
  logic [31:0]        r_d_pend_addr;
  logic [3:0]         r_d_pend_we;
  logic [31:0]        r_d_pend_wdata;
  logic               r_d_infl;
  logic               r_d_oow;
  logic [1:0]         r_d_off;
  logic [31:0]        r_d_hold;
  logic               r_d_ovr;

  logic [c_CNT_W-1:0] r_starve;

  logic               w_i_ready;
  logic               w_d_ready;
  logic               w_i_free;
  logic               w_d_free;
  logic               w_i_cap;
  logic               w_d_req;
  logic               w_d_cap;
  logic               w_i_cand;
  logic [ADDR_W-1:0]  w_i_addr;
  logic               w_d_cand;
  logic [31:0]        w_d_addr;
  logic [3:0]         w_d_we;
  logic [31:0]        w_d_wdata;
  logic [1:0]         w_off;
  logic               w_d_in_win;
  logic               w_d_ram;
  logic               w_d_oow_go;
  logic               w_contest;
  logic               w_i_grant;
  logic               w_d_grant;
  logic [3:0]         w_we_sh;
  logic [31:0]        w_d_rsh;
  logic               w_unused_ok;

  // Ready outputs are forced low while reset is asserted.
  assign w_i_ready = rst & r_i_infl;
  assign w_d_ready = rst & (r_d_infl | r_d_oow);

  assign w_i_free  = !r_i_pend && (!r_i_infl || w_i_ready);
  assign w_d_free  = !r_d_pend && (!(r_d_infl || r_d_oow) || w_d_ready);

  assign w_i_cap   = i_oe && w_i_free;
  assign w_d_req   = d_oe || (d_we != 4'b0000);
  assign w_d_cap   = w_d_req && w_d_free;

  // A pending slot takes priority over a same-cycle bypass capture.
  assign w_i_cand  = r_i_pend | w_i_cap;
  assign w_i_addr  = r_i_pend ? r_i_pend_addr : i_addr;

  assign w_d_cand  = r_d_pend | w_d_cap;
  assign w_d_addr  = r_d_pend ? r_d_pend_addr  : d_addr;
  assign w_d_we    = r_d_pend ? r_d_pend_we    : d_we;
  assign w_d_wdata = r_d_pend ? r_d_pend_wdata : d_wdata;
  assign w_off     = w_d_addr[1:0];

  assign w_d_in_win = (w_d_addr[31:ADDR_W] == BASE[31:ADDR_W]);
  assign w_d_ram    = w_d_cand &  w_d_in_win;
  assign w_d_oow_go = w_d_cand & ~w_d_in_win;

  assign w_contest  = w_i_cand & w_d_ram;
  assign w_i_grant  = w_i_cand & (~w_d_ram | (r_starve == c_LIMIT));
  assign w_d_grant  = w_d_ram & ~w_i_grant;

  assign w_we_sh    = w_d_we << w_off;

  assign ram_en     = rst & (w_i_grant | w_d_grant);
  assign ram_addr   = w_d_grant ? w_d_addr[ADDR_W-1:2] : w_i_addr[ADDR_W-1:2];
  assign ram_we     = (rst & w_d_grant) ? w_we_sh : 4'b0000;
  assign ram_wdata  = w_d_wdata << {w_off, 3'b000};

  assign w_d_rsh    = ram_rdata >> {r_d_off, 3'b000};

  assign i_ready    = w_i_ready;
  assign d_ready    = w_d_ready;
  assign d_overrun  = r_d_ovr;

  always_comb begin
    i_rdata = r_i_hold;
    d_rdata = r_d_hold;
    if (w_i_ready) begin
      i_rdata = ram_rdata;
    end
    if (rst && r_d_infl) begin
      d_rdata = w_d_rsh;
    end else if (rst && r_d_oow) begin
      d_rdata = 32'h0000_0000;
    end
  end

  // Fetch addresses are word aligned; the byte offset is never decoded.
  assign w_unused_ok = &{1'b0, i_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_pend       <= 1'b0;
      r_i_pend_addr  <= '0;
      r_i_infl       <= 1'b0;
      r_i_hold       <= 32'h0000_0000;
      r_d_pend       <= 1'b0;
      r_d_pend_addr  <= 32'h0000_0000;
      r_d_pend_we    <= 4'b0000;
      r_d_pend_wdata <= 32'h0000_0000;
      r_d_infl       <= 1'b0;
      r_d_oow        <= 1'b0;
      r_d_off        <= 2'b00;
      r_d_hold       <= 32'h0000_0000;
      r_d_ovr        <= 1'b0;
      r_starve       <= '0;
    end else begin
      r_i_pend <= w_i_cand & ~w_i_grant;
      r_i_infl <= w_i_grant;
      if (w_i_cap) begin
        r_i_pend_addr <= i_addr;
      end
      if (w_i_ready) begin
        r_i_hold <= ram_rdata;
      end

      // Out-of-window accesses never wait, so only RAM-bound data can pend.
      r_d_pend <= w_d_ram & ~w_d_grant;
      r_d_infl <= w_d_grant;
      r_d_oow  <= w_d_oow_go;
      if (w_d_cap) begin
        r_d_pend_addr  <= d_addr;
        r_d_pend_we    <= d_we;
        r_d_pend_wdata <= d_wdata;
      end
      if (w_d_grant) begin
        r_d_off <= w_off;
      end
      if (w_d_ready) begin
        r_d_hold <= d_rdata;
      end
      if (w_d_req && !w_d_free) begin
        r_d_ovr <= 1'b1;
      end

      if (w_i_grant) begin
        r_starve <= '0;
      end else if (w_contest && w_d_grant && (r_starve != c_LIMIT)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Brief    : Directed vectors, corner sequences and randomized traffic
//            checked against a memory/scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LIMIT  = 4;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_oe = 1'b0;
  logic [31:0]       i_rdata;
  logic              i_ready;
  logic [31:0]       d_addr = '0;
  logic              d_oe = 1'b0;
  logic [3:0]        d_we = '0;
  logic [31:0]       d_wdata = '0;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              d_overrun;
  logic [ADDR_W-3:0] ram_addr;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .BASE(32'h80000000), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_addr(d_addr), .d_oe(d_oe), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_overrun(d_overrun),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    if (w == 4) return 32'h0000_0013;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Unified RAM: synchronous read, byte-lane write, old data on a write cycle.
  logic [31:0] mem [WORDS];
  bit          mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int w = 0; w < WORDS; w++) mem[w] <= init_word(w);
      mem_ok <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int k = 0; k < 4; k++)
        if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        i_oe;
    logic [15:0] i_addr;
    logic        d_oe;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_en;
    logic [13:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic        e_ir;
    logic        ci;
    logic [31:0] e_ird;
    logic        e_dr;
    logic        cd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic r, input logic ioe, input logic [15:0] ia,
                             input logic doe, input logic [3:0] dwe, input logic [31:0] da,
                             input logic [31:0] dwd, input logic en, input logic [13:0] ea,
                             input logic [3:0] ewe, input logic [31:0] ewd,
                             input logic eir, input logic ci, input logic [31:0] eird,
                             input logic edr, input logic cd, input logic [31:0] edrd);
    vec_t x;
    x.rst = r; x.i_oe = ioe; x.i_addr = ia; x.d_oe = doe; x.d_we = dwe;
    x.d_addr = da; x.d_wdata = dwd; x.e_en = en; x.e_addr = ea; x.e_we = ewe;
    x.e_wd = ewd; x.e_ir = eir; x.ci = ci; x.e_ird = eird; x.e_dr = edr;
    x.cd = cd; x.e_drd = edrd;
    return x;
  endfunction

  // Fetch starved by back-to-back data; optionally probes overrun on the pending slot.
  task automatic starve_seq(input bit probe);
    for (int k = 0; k <= LIMIT; k++) begin
      @(negedge clk); cyc++;
      i_oe = (k == 0); i_addr = 16'h0100;
      d_oe = 1'b1; d_we = 4'b0000; d_addr = 32'h80008000 + 32'(4 * k);
      #1;
      chk($sformatf("starve k%0d ram_en", k), 32'(ram_en), 1);
      chk($sformatf("starve k%0d ram_addr", k), 32'(ram_addr),
          (k < LIMIT) ? 32'h2000 + 32'(k) : 32'h0040);
      if (k >= 1) begin
        chk($sformatf("starve k%0d d_ready", k), 32'(d_ready), 1);
        chk($sformatf("starve k%0d d_rdata", k), d_rdata, init_word(32'h2000 + k - 1));
      end
    end
    @(negedge clk); cyc++;
    i_oe = 1'b0; d_oe = probe; d_addr = 32'h80008040;
    #1;
    chk("starve fetch i_ready", 32'(i_ready), 1);
    chk("starve fetch i_rdata", i_rdata, init_word(32'h40));
    chk("starve pending data issue", 32'(ram_addr), 32'h2000 + LIMIT);
    chk("starve pending data d_ready", 32'(d_ready), 0);
    @(negedge clk); cyc++;
    d_oe = 1'b0;
    #1;
    chk("starve data d_ready", 32'(d_ready), 1);
    chk("starve data d_rdata", d_rdata, init_word(32'h2000 + LIMIT));
    chk("starve dropped request not issued", 32'(ram_en), 0);
    chk("starve d_overrun", 32'(d_overrun), 32'(probe));
    @(negedge clk); cyc++;
    #1;
    chk("starve d_overrun sticky", 32'(d_overrun), 32'(probe));
    chk("starve idle d_ready", 32'(d_ready), 0);
  endtask

  logic [31:0] shadow [WORDS];
  bit          ib, db, dchk, doow;
  int          it, dt;
  logic [31:0] iexp, dexp;

  task automatic rnd_check();
    int lat;
    if (i_ready) begin
      chk("rnd fetch ready expected", 32'(ib), 1);
      if (ib) begin
        lat = cyc - it;
        chk("rnd fetch rdata", i_rdata, iexp);
        chk("rnd fetch latency within bound", 32'(lat >= 1 && lat <= 1 + LIMIT), 1);
        ib = 1'b0;
      end
    end else if (ib && (cyc - it) > 1 + LIMIT) begin
      chk("rnd fetch wait bound", 32'(cyc - it), 32'(1 + LIMIT));
      ib = 1'b0;
    end
    if (d_ready) begin
      chk("rnd data ready expected", 32'(db), 1);
      if (db) begin
        lat = cyc - dt;
        if (doow) chk("rnd oow latency", 32'(lat), 1);
        else      chk("rnd data latency within bound", 32'(lat >= 1 && lat <= 2), 1);
        if (dchk) chk("rnd data rdata", d_rdata, dexp);
        db = 1'b0;
      end
    end else if (db && (cyc - dt) > 2) begin
      chk("rnd data wait bound", 32'(cyc - dt), 2);
      db = 1'b0;
    end
    chk("rnd d_overrun", 32'(d_overrun), 0);
  endtask

  task automatic rnd_drive(input bit allow);
    int w, off, kind, sz;
    logic [3:0] we;
    if (allow && !ib && $urandom_range(0, 99) < 60) begin
      w = $urandom_range(16, WORDS / 2 - 1);
      i_addr = 16'(w << 2); i_oe = 1'b1;
      ib = 1'b1; it = cyc; iexp = init_word(w);
    end else if (ib && $urandom_range(0, 1) == 1) begin
      i_oe = 1'b1;
    end else begin
      i_oe = 1'b0; i_addr = 16'($urandom);
    end
    d_oe = 1'b0; d_we = 4'b0000; d_wdata = $urandom; d_addr = $urandom;
    if (allow && !db && $urandom_range(0, 99) < 60) begin
      kind = $urandom_range(0, 9); off = $urandom_range(0, 3); sz = $urandom_range(0, 2);
      we = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
      w = $urandom_range(WORDS / 2, WORDS - 1);
      doow = (kind < 2); dchk = 1'b0; db = 1'b1; dt = cyc;
      if (doow) d_addr = {16'($urandom_range(0, 16'h7FFF)), 16'($urandom)};
      else      d_addr = 32'h80000000 | 32'(w << 2) | 32'(off);
      if (kind == 0 || (kind >= 2 && kind < 6)) begin
        d_oe = 1'b1; dchk = 1'b1;
        dexp = doow ? 32'h0 : (shadow[w] >> (8 * off));
      end else begin
        d_we = we; d_oe = 1'($urandom_range(0, 1));
        if (!doow)
          for (int k = 0; k < 4; k++)
            if (we[k] && (k + off) < 4) shadow[w][8*(k+off) +: 8] = d_wdata[8*k +: 8];
      end
    end
  endtask

  initial begin
    for (int w = 0; w < WORDS; w++) shadow[w] = init_word(w);
    ib = 0; db = 0; dchk = 0; doow = 0; it = 0; dt = 0; iexp = 0; dexp = 0;

    //        rst ioe iaddr     doe dwe      daddr          dwdata        en  eaddr    ewe      ewdata        eir ci eird            edr cd edrd
    vt.push_back(v(0, 1, 16'h0040, 1, 4'b0000, 32'h80008010, 32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(0, 1, 16'h0040, 1, 4'b0000, 32'h80008010, 32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 1, 16'h0040, 1, 4'b0000, 32'h80008010, 32'h0,        1, 14'h2004, 4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 1, 16'h0040, 0, 4'b0000, 32'h0,        32'h0,        1, 14'h0010, 4'b0000, 32'h0,        0, 0, 32'h0,          1, 1, init_word(32'h2004)));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        1, 1, init_word(32'h10), 0, 0, 32'h0));
    vt.push_back(v(1, 1, 16'h0010, 0, 4'b0000, 32'h0,        32'h0,        1, 14'h0004, 4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 1, 16'h0014, 0, 4'b0000, 32'h0,        32'h0,        1, 14'h0005, 4'b0000, 32'h0,        1, 1, 32'h00000013,   0, 0, 32'h0));
    vt.push_back(v(1, 1, 16'h0018, 0, 4'b0000, 32'h0,        32'h0,        1, 14'h0006, 4'b0000, 32'h0,        1, 1, init_word(5),   0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        1, 1, init_word(6),   0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 1, init_word(6),   0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0001, 32'h80000003, 32'h000000AB, 1, 14'h0000, 4'b1000, 32'hAB000000, 0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 1, 4'b0000, 32'h80000003, 32'h0,        1, 14'h0000, 4'b0000, 32'h0,        0, 0, 32'h0,          1, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          1, 1, 32'h000000AB));
    vt.push_back(v(1, 1, 16'h0020, 1, 4'b0000, 32'h00001000, 32'h0,        1, 14'h0008, 4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        1, 1, init_word(8),   1, 1, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 1, 4'b0000, 32'h00001000, 32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          1, 1, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0011, 32'h80000006, 32'h1234CDEF, 1, 14'h0001, 4'b1100, 32'hCDEF0000, 0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b1111, 32'h80000005, 32'h11223344, 1, 14'h0001, 4'b1110, 32'h22334400, 0, 0, 32'h0,          1, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          1, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 1, 4'b0000, 32'h80000004, 32'h0,        1, 14'h0001, 4'b0000, 32'h0,        0, 0, 32'h0,          0, 0, 32'h0));
    vt.push_back(v(1, 0, 16'h0000, 0, 4'b0000, 32'h0,        32'h0,        0, 14'h0,    4'b0000, 32'h0,        0, 0, 32'h0,          1, 1,
                   32'h22334400 | (init_word(1) & 32'h000000FF)));

    for (int r = 0; r < vt.size(); r++) begin
      @(negedge clk); cyc++;
      rst = vt[r].rst; i_oe = vt[r].i_oe; i_addr = vt[r].i_addr;
      d_oe = vt[r].d_oe; d_we = vt[r].d_we; d_addr = vt[r].d_addr; d_wdata = vt[r].d_wdata;
      #1;
      chk($sformatf("row%0d ram_en", r), 32'(ram_en), 32'(vt[r].e_en));
      if (vt[r].e_en) chk($sformatf("row%0d ram_addr", r), 32'(ram_addr), 32'(vt[r].e_addr));
      chk($sformatf("row%0d ram_we", r), 32'(ram_we), 32'(vt[r].e_we));
      if (vt[r].e_we != 4'b0000) chk($sformatf("row%0d ram_wdata", r), ram_wdata, vt[r].e_wd);
      chk($sformatf("row%0d i_ready", r), 32'(i_ready), 32'(vt[r].e_ir));
      chk($sformatf("row%0d d_ready", r), 32'(d_ready), 32'(vt[r].e_dr));
      if (vt[r].ci) chk($sformatf("row%0d i_rdata", r), i_rdata, vt[r].e_ird);
      if (vt[r].cd) chk($sformatf("row%0d d_rdata", r), d_rdata, vt[r].e_drd);
      chk($sformatf("row%0d d_overrun", r), 32'(d_overrun), 0);
    end

    starve_seq(1'b0);
    starve_seq(1'b1);

    // Reset while a load is in flight.
    @(negedge clk); cyc++;
    i_oe = 1'b0; d_oe = 1'b1; d_we = 4'b0000; d_addr = 32'h80008008;
    #1;
    chk("midreset load issued", 32'(ram_en), 1);
    @(negedge clk); cyc++;
    d_oe = 1'b0; rst = 1'b0;
    #1;
    chk("midreset d_ready during reset", 32'(d_ready), 0);
    chk("midreset ram_en during reset", 32'(ram_en), 0);
    @(negedge clk); cyc++;
    rst = 1'b1;
    #1;
    chk("midreset d_ready after reset", 32'(d_ready), 0);
    chk("midreset d_overrun cleared", 32'(d_overrun), 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); cyc++;
      rnd_check();
      rnd_drive(1'b1);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); cyc++;
      rnd_check();
      rnd_drive(1'b0);
    end
    chk("rnd fetch drained", 32'(ib), 0);
    chk("rnd data drained", 32'(db), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
